// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the RV32M multiply/divide unit: the eight operation
// codes as seen on SELECT ({func3, func7[0], func7[5]}), the sequencer state
// encoding and small decode helpers. The ALU decode imports the same package
// so both sides agree on the encodings.
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int CNT_W      = 6;
  localparam int ITERATIONS = 32;

  // Every M-extension code has func7 = 0000001, so the low two bits are
  // always 2'b10; the upper three bits are func3.
  typedef enum logic [4:0] {
    OP_MUL    = 5'b00010,
    OP_MULH   = 5'b00110,
    OP_MULHSU = 5'b01010,
    OP_MULHU  = 5'b01110,
    OP_DIV    = 5'b10010,
    OP_DIVU   = 5'b10110,
    OP_REM    = 5'b11010,
    OP_REMU   = 5'b11110
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for any of the eight M-extension codes.
  function automatic logic op_valid(input logic [4:0] sel);
    return sel[1:0] == 2'b10;
  endfunction

  // Division family: func3[2] set.
  function automatic logic op_is_div(input logic [4:0] sel);
    return sel[4];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic op_is_rem(input logic [4:0] sel);
    return sel[4] && sel[3];
  endfunction

  // rs1 treated as signed: MULH, MULHSU, DIV, REM.
  function automatic logic op_signed_a(input logic [4:0] sel);
    return (sel == OP_MULH) || (sel == OP_MULHSU) ||
           (sel == OP_DIV)  || (sel == OP_REM);
  endfunction

  // rs2 treated as signed: MULH, DIV, REM.
  function automatic logic op_signed_b(input logic [4:0] sel);
    return (sel == OP_MULH) || (sel == OP_DIV) || (sel == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// -----------------------------------------------------------------------------
// muldiv_datapath
// 64-bit accumulator with one shift-add (multiply) or one restoring
// subtract (divide) step per cycle, plus the combinational sign fix-up and
// result selection used in the FIX state.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   load         latch operand magnitudes (start of an operation)
//   load_div     operation being loaded is a divide
//   a_mag, b_mag operand magnitudes (rs1, rs2)
//   step         perform one iteration
//   op           latched operation code (selects step kind and result)
//   neg_prod     negate the 64-bit product
//   neg_quot     negate the quotient
//   neg_rem      negate the remainder
//   div_zero     divisor was zero (quotient forced to all ones)
//   fix_result   sign-corrected, selected 32-bit result
// -----------------------------------------------------------------------------
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            load_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  input  logic            step,
  input  logic [4:0]      op,
  input  logic            neg_prod,
  input  logic            neg_quot,
  input  logic            neg_rem,
  input  logic            div_zero,
  output logic [XLEN-1:0] fix_result
);

  // Multiply: acc = {partial product, multiplier}, opnd = multiplicand.
  // Divide:   acc = {remainder, dividend -> quotient}, opnd = divisor.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_next = acc_q;
    mul_sum  = '0;
    div_diff = '0;
    if (op_is_div(op)) begin
      // Shift in the next dividend bit, then try subtracting the divisor.
      div_diff = {1'b0, acc_q[2*XLEN-1:XLEN-1]} - {2'b00, opnd_q};
      if (!div_diff[XLEN+1])
        acc_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_next = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      // Add the multiplicand if the current multiplier bit is set, then
      // shift the whole accumulator right, carry included.
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                 {1'b0, (acc_q[0] ? opnd_q : '0)};
      acc_next = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opnd_q <= '0;
    end else if (load) begin
      acc_q  <= {{XLEN{1'b0}}, (load_div ? a_mag : b_mag)};
      opnd_q <= load_div ? b_mag : a_mag;
    end else if (step) begin
      acc_q  <= acc_next;
    end
  end

  always_comb begin
    product    = neg_prod ? -acc_q : acc_q;
    quotient   = neg_quot ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    remainder  = neg_rem  ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    fix_result = '0;
    case (op)
      OP_MUL:                       fix_result = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = product[2*XLEN-1:XLEN];
      // A zero divisor leaves an all-ones magnitude; with a negative
      // dividend the sign fix would turn it into 1, so force it here.
      OP_DIV, OP_DIVU:              fix_result = div_zero ? '1 : quotient;
      OP_REM, OP_REMU:              fix_result = remainder;
      default:                      fix_result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Iterative RV32M multiply/divide unit. Accepts an operation in IDLE or
// DONE_S, iterates 32 cycles in CALC, corrects signs in FIX and presents the
// registered result with a one-cycle DONE pulse. Divide-by-zero and signed
// overflow can optionally complete in one cycle (BYPASS_SPECIAL).
//
// Ports
//   CLK     clock, rising edge
//   RESETN  asynchronous active-low reset
//   START   request to begin an operation
//   SELECT  operation code {func3, func7[0], func7[5]}
//   DATA1   rs1 (multiplicand / dividend)
//   DATA2   rs2 (multiplier / divisor)
//   FLUSH   abort any operation in progress
//   BUSY    high in CALC and FIX
//   DONE    high for the one cycle spent in DONE_S
//   RESULT  registered result
// -----------------------------------------------------------------------------
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter bit BYPASS_SPECIAL = 1'b1
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);
  localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]      op_q;
  logic            neg_prod_q, neg_quot_q, neg_rem_q, div_zero_q;
  logic [XLEN-1:0] result_q;

  logic            accept, bypass;
  logic            sign_a, sign_b;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] bypass_result;
  logic [XLEN-1:0] fix_result;

  // Operand decode at acceptance time.
  always_comb begin
    accept = START && op_valid(SELECT) && !FLUSH &&
             (state_q == ST_IDLE || state_q == ST_DONE);
    sign_a = op_signed_a(SELECT) && DATA1[XLEN-1];
    sign_b = op_signed_b(SELECT) && DATA2[XLEN-1];
    a_mag  = sign_a ? -DATA1 : DATA1;
    b_mag  = sign_b ? -DATA2 : DATA2;

    div_zero = op_is_div(SELECT) && (DATA2 == '0);
    div_ovf  = op_is_div(SELECT) && op_signed_b(SELECT) &&
               (DATA1 == INT_MIN) && (DATA2 == '1);
    bypass   = BYPASS_SPECIAL && (div_zero || div_ovf);

    if (div_zero)
      bypass_result = op_is_rem(SELECT) ? DATA1 : '1;
    else
      bypass_result = op_is_rem(SELECT) ? '0 : INT_MIN;
  end

  // Next-state logic; FLUSH overrides everything, including a new START.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = bypass ? ST_DONE : ST_CALC;
      ST_CALC: if (cnt_q == LAST_ITER) state_d = ST_FIX;
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: begin
        if (accept) state_d = bypass ? ST_DONE : ST_CALC;
        else        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (FLUSH) state_d = ST_IDLE;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        cnt_q      <= '0;
        op_q       <= SELECT;
        neg_prod_q <= !op_is_div(SELECT) && (sign_a ^ sign_b);
        neg_quot_q <= op_is_div(SELECT) && (sign_a ^ sign_b);
        neg_rem_q  <= op_is_div(SELECT) && sign_a;
        div_zero_q <= div_zero;
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (accept && bypass)
        result_q <= bypass_result;
      else if (state_q == ST_FIX && !FLUSH)
        result_q <= fix_result;
    end
  end

  muldiv_datapath u_datapath (
    .clk        (CLK),
    .rst_n      (RESETN),
    .load       (accept),
    .load_div   (op_is_div(SELECT)),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .step       (state_q == ST_CALC),
    .op         (op_q),
    .neg_prod   (neg_prod_q),
    .neg_quot   (neg_quot_q),
    .neg_rem    (neg_rem_q),
    .div_zero   (div_zero_q),
    .fix_result (fix_result)
  );

  assign BUSY   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign DONE   = (state_q == ST_DONE);
  assign RESULT = result_q;

endmodule
